// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the memory port arbiter and its fair-pick helper.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_fair_pick.sv
// Combinational owner select: core has fixed priority unless port D has waited
// MAX_WAIT lost arbitrations, in which case D wins.
module arb_fair_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              c_req,
    input  logic              d_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output owner_e            owner,
    output logic              valid
);

    logic d_due;

    assign d_due = (wait_cnt >= WAIT_W'(MAX_WAIT));

    always_comb begin
        valid = c_req | d_req;
        owner = OWN_C;
        if (d_req && (!c_req || d_due)) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory between the core (port C) and a loader (port D);
// each access is grant, MEM_LAT strobe cycles, then a one-cycle done.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d, pick_owner;
    logic              pick_valid;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        lat_q, lat_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic              c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
    logic              c_done_q, c_done_d, d_done_q, d_done_d;

    arb_fair_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .c_req    (c_req),
        .d_req    (d_req),
        .wait_cnt (wait_q),
        .owner    (pick_owner),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wait_d    = wait_q;
        lat_d     = lat_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        c_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        c_done_d  = 1'b0;
        d_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    owner_d = pick_owner;
                    lat_d   = 4'(MEM_LAT - 1);
                    if (pick_owner == OWN_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        d_gnt_d = 1'b1;
                    end else begin
                        we_d    = c_we;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                        c_gnt_d = 1'b1;
                    end
                    // Fairness counter only moves on contested arbitrations or a lone D grant.
                    if (c_req && d_req) begin
                        wait_d = (pick_owner == OWN_D) ? '0 : sat_inc(wait_q);
                    end else if (pick_owner == OWN_D) begin
                        wait_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (lat_q == 4'd0) begin
                    state_d = DONE;
                    if (owner_q == OWN_D) begin
                        d_done_d = 1'b1;
                        if (!we_q) d_rdata_d = mem_rdata;
                    end else begin
                        c_done_d = 1'b1;
                        if (!we_q) c_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_C;
            wait_q    <= '0;
            lat_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            c_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            c_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            lat_q     <= lat_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
            c_gnt_q   <= c_gnt_d;
            d_gnt_q   <= d_gnt_d;
            c_done_q  <= c_done_d;
            d_done_q  <= d_done_d;
        end
    end

    // Strobes decode straight from state flops so an async reset drops them at once.
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) &&  we_q;
    assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign busy      = (state_q != IDLE);

    assign c_gnt   = c_gnt_q;
    assign d_gnt   = d_gnt_q;
    assign c_done  = c_done_q;
    assign d_done  = d_done_q;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share one input
// stream and are each compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;

    logic [1:0] c_gnt_o, d_gnt_o, c_done_o, d_done_o, mem_read_o, mem_write_o, busy_o;
    logic [AW-1:0] mem_addr_o [2];
    logic [DW-1:0] mem_wdata_o [2];
    logic [DW-1:0] c_rdata_o [2];
    logic [DW-1:0] d_rdata_o [2];
    logic [DW-1:0] mem_rdata_i [2];

    // Bench-side memories, one per instance, with a preload port.
    logic [DW-1:0] bmem [2][32];
    logic pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    int checks = 0;
    int errors = 0;

    // Reference model state, per instance.
    int            m_phase [2];
    bit            m_own_d [2];
    bit            m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rd_c [2];
    logic [DW-1:0] m_rd_d [2];
    int            m_wait [2];
    logic [DW-1:0] refmem [2][32];

    bit gnt_log0 [$];
    bit gnt_log1 [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_WAIT(MAX_WAIT)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt_o[0]), .c_done(c_done_o[0]), .c_rdata(c_rdata_o[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_o[0]), .d_done(d_done_o[0]), .d_rdata(d_rdata_o[0]),
        .mem_read(mem_read_o[0]), .mem_write(mem_write_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0]), .busy(busy_o[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_WAIT(MAX_WAIT)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt_o[1]), .c_done(c_done_o[1]), .c_rdata(c_rdata_o[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_o[1]), .d_done(d_done_o[1]), .d_rdata(d_rdata_o[1]),
        .mem_read(mem_read_o[1]), .mem_write(mem_write_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1]), .busy(busy_o[1])
    );

    assign mem_rdata_i[0] = bmem[0][mem_addr_o[0]];
    assign mem_rdata_i[1] = bmem[1][mem_addr_o[1]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pl_en) bmem[i][pl_addr] <= pl_data;
            else if (mem_write_o[i]) bmem[i][mem_addr_o[i]] <= mem_wdata_o[i];
        end
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int i);
        m_phase[i] = 0;
        m_own_d[i] = 1'b0;
        m_we[i]    = 1'b0;
        m_addr[i]  = '0;
        m_wdata[i] = '0;
        m_rd_c[i]  = '0;
        m_rd_d[i]  = '0;
        m_wait[i]  = 0;
    endtask

    // Phase 0 = no access; 1..LAT = strobe cycles; LAT+1 = done cycle.
    task automatic model_edge(input int i);
        bit pick_d;
        if (!rst) begin
            model_reset(i);
        end else if (m_phase[i] != 0) begin
            if (m_phase[i] == lat_of(i)) begin
                if (m_we[i]) refmem[i][m_addr[i]] = m_wdata[i];
                else if (m_own_d[i]) m_rd_d[i] = refmem[i][m_addr[i]];
                else m_rd_c[i] = refmem[i][m_addr[i]];
            end
            m_phase[i] = (m_phase[i] == lat_of(i) + 1) ? 0 : m_phase[i] + 1;
        end else if (c_req || d_req) begin
            pick_d = d_req && (!c_req || m_wait[i] >= MAX_WAIT);
            if (c_req && d_req) m_wait[i] = pick_d ? 0 : ((m_wait[i] >= 15) ? 15 : m_wait[i] + 1);
            else if (pick_d) m_wait[i] = 0;
            m_own_d[i] = pick_d;
            m_we[i]    = pick_d ? d_we : c_we;
            m_addr[i]  = pick_d ? d_addr : c_addr;
            m_wdata[i] = pick_d ? d_wdata : c_wdata;
            m_phase[i] = 1;
        end
    endtask

    function automatic logic [107:0] exp_vec(input int i);
        logic b, cg, dg, cd, dd, mr, mw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        {b, cg, dg, cd, dd, mr, mw} = '0;
        a  = '0;
        wd = '0;
        if (m_phase[i] >= 1 && m_phase[i] <= lat_of(i)) begin
            b  = 1'b1;
            mr = !m_we[i];
            mw = m_we[i];
            a  = m_addr[i];
            wd = m_wdata[i];
            if (m_phase[i] == 1) begin
                cg = !m_own_d[i];
                dg = m_own_d[i];
            end
        end else if (m_phase[i] == lat_of(i) + 1) begin
            b  = 1'b1;
            cd = !m_own_d[i];
            dd = m_own_d[i];
        end
        return {b, cg, dg, cd, dd, mr, mw, a, wd, m_rd_c[i], m_rd_d[i]};
    endfunction

    function automatic logic [107:0] obs_vec(input int i);
        return {busy_o[i], c_gnt_o[i], d_gnt_o[i], c_done_o[i], d_done_o[i],
                mem_read_o[i], mem_write_o[i], mem_addr_o[i], mem_wdata_o[i],
                c_rdata_o[i], d_rdata_o[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            assert (obs_vec(i) === exp_vec(i)) else begin
                errors++;
                $error("FAIL outputs_lat%0d observed=%h expected=%h", lat_of(i), obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic random_inputs();
        c_req = 1'($urandom_range(0, 1)); c_we = 1'($urandom_range(0, 1));
        c_addr = 5'($urandom_range(0, 31)); c_wdata = $urandom;
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = 5'($urandom_range(0, 31)); d_wdata = $urandom;
    endtask

    initial begin
        int n_wr0, n_wr1, n_bad_addr, n_done, n_gnt;

        // Reset held with random inputs while both memories are preloaded.
        rst = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        idle_inputs();
        for (int j = 0; j < 32; j++) begin
            random_inputs();
            pl_en   = 1'b1;
            pl_addr = 5'(j);
            pl_data = (j == 5) ? 32'hDEADBEEF : $urandom;
            refmem[0][j] = pl_data;
            refmem[1][j] = pl_data;
            cycle();
        end
        pl_en = 1'b0;
        idle_inputs();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) cycle();
        check("idle_busy_after_reset", 32'(busy_o), 32'd0);

        // Core read of address 5.
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd5; c_wdata = 32'h0;
        cycle();
        check("core_read_gnt_lat1", 32'(c_gnt_o[0]), 32'd1);
        check("core_read_strobe_lat1", 32'(mem_read_o[0]), 32'd1);
        check("core_read_addr_lat1", 32'(mem_addr_o[0]), 32'd5);
        cycle();
        check("core_read_done_lat1", 32'(c_done_o[0]), 32'd1);
        check("core_read_data_lat1", c_rdata_o[0], 32'hDEADBEEF);
        c_req = 1'b0;
        for (int j = 0; j < 5; j++) cycle();
        check("core_read_data_lat3", c_rdata_o[1], 32'hDEADBEEF);

        // Port D write of address 9, then a core read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 32'h12345678;
        n_wr0 = 0; n_wr1 = 0; n_bad_addr = 0; n_done = 0;
        for (int j = 0; j < 8; j++) begin
            cycle();
            if (j == 0) d_req = 1'b0;
            n_wr0 += int'(mem_write_o[0]);
            n_wr1 += int'(mem_write_o[1]);
            if (mem_write_o[1] && mem_addr_o[1] != 5'd9) n_bad_addr++;
            n_done += int'(d_done_o[1]);
        end
        check("d_write_strobe_cycles_lat1", n_wr0, 1);
        check("d_write_strobe_cycles_lat3", n_wr1, 3);
        check("d_write_addr_lat3", n_bad_addr, 0);
        check("d_write_done_count_lat3", n_done, 1);
        idle_inputs();
        c_req = 1'b1; c_addr = 5'd9;
        cycle();
        c_req = 1'b0;
        for (int j = 0; j < 6; j++) cycle();
        check("readback_lat1", c_rdata_o[0], 32'h12345678);
        check("readback_lat3", c_rdata_o[1], 32'h12345678);

        // Starvation: both requests held continuously.
        gnt_log0.delete();
        gnt_log1.delete();
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd4;
        for (int j = 0; j < 60; j++) begin
            cycle();
            if (c_gnt_o[0]) gnt_log0.push_back(1'b0);
            if (d_gnt_o[0]) gnt_log0.push_back(1'b1);
            if (c_gnt_o[1]) gnt_log1.push_back(1'b0);
            if (d_gnt_o[1]) gnt_log1.push_back(1'b1);
        end
        check("grant_count_lat1", 32'(gnt_log0.size() >= 10), 32'd1);
        check("grant_count_lat3", 32'(gnt_log1.size() >= 10), 32'd1);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("grant_order_lat1[%0d]", j),
                  (j < gnt_log0.size()) ? 32'(gnt_log0[j]) : 32'd2, 32'(j % 5 == 4));
            check($sformatf("grant_order_lat3[%0d]", j),
                  (j < gnt_log1.size()) ? 32'(gnt_log1[j]) : 32'd2, 32'(j % 5 == 4));
        end
        idle_inputs();
        for (int j = 0; j < 8; j++) cycle();

        // Core drops its request in the second access cycle.
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'($urandom_range(0, 31));
        cycle();
        cycle();
        c_req = 1'b0;
        n_done = 0; n_gnt = 0;
        for (int j = 0; j < 8; j++) begin
            cycle();
            n_done += int'(c_done_o[1]);
            n_gnt  += int'(c_gnt_o[1]) + int'(d_gnt_o[1]);
        end
        check("dropped_req_done_count", n_done, 1);
        check("dropped_req_no_regrant", n_gnt, 0);

        // Reset asserted mid-access.
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd7;
        cycle();
        c_req = 1'b0;
        cycle();
        rst = 1'b0;
        #1;
        check("reset_mid_access_read_strobe", 32'(mem_read_o), 32'd0);
        check("reset_mid_access_busy", 32'(busy_o), 32'd0);
        model_reset(0);
        model_reset(1);
        cycle();
        cycle();
        rst = 1'b1;
        n_done = 0;
        for (int j = 0; j < 6; j++) begin
            cycle();
            n_done += int'(c_done_o[0]) + int'(c_done_o[1]) + int'(d_done_o[0]) + int'(d_done_o[1]);
        end
        check("no_done_after_reset", n_done, 0);
        c_req = 1'b1; c_we = 1'b1; c_addr = 5'd12; c_wdata = $urandom;
        cycle();
        c_req = 1'b0;
        n_done = 0;
        for (int j = 0; j < 6; j++) begin
            cycle();
            n_done += int'(c_done_o[1]);
        end
        check("service_after_reset_lat3", n_done, 1);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 400; j++) begin
            random_inputs();
            rst = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst = 1'b1;
        idle_inputs();
        for (int j = 0; j < 8; j++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
